// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - multi-domain reset release sequencer
// Releases STAGES reset domains in order, gated by per-domain acks, gaps and timeouts.
module rst_seq #(
   parameter int          STAGES  = 4,
   parameter logic [31:0] GAP     = 32'd1000,
   parameter logic [31:0] TIMEOUT = 32'h000fffff
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic [STAGES-1:0] i_ack,
   output logic [STAGES-1:0] o_rstn,
   output logic [2:0]        o_stage,
   output logic              o_done,
   output logic              o_err
);

   typedef enum logic [2:0] {S_IDLE, S_GAP, S_WAIT, S_DONE, S_ERR} state_t;

   localparam logic [2:0]        LAST = 3'(STAGES - 1);
   localparam logic [STAGES-1:0] ONE  = STAGES'(1);

   state_t            state;
   logic [31:0]       cnt;
   logic [2:0]        stg;
   logic [STAGES-1:0] sel;
   logic              ack_cur;

   // One-hot mask of the stage being processed; acks of other stages are ignored here.
   assign sel     = ONE << stg;
   assign ack_cur = |(i_ack & sel);
   assign o_stage = stg;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state  <= S_IDLE;
         cnt    <= 32'd0;
         stg    <= 3'd0;
         o_rstn <= '0;
         o_done <= 1'b0;
         o_err  <= 1'b0;
      end else if (!i_start) begin
         state  <= S_IDLE;
         cnt    <= 32'd0;
         stg    <= 3'd0;
         o_rstn <= '0;
         o_done <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state  <= S_GAP;
               cnt    <= 32'd0;
               stg    <= 3'd0;
               o_rstn <= '0;
            end
            S_GAP: begin
               if (cnt == GAP - 32'd1) begin
                  o_rstn <= o_rstn | sel;
                  cnt    <= 32'd0;
                  state  <= S_WAIT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_WAIT: begin
               // An ack on the timeout edge still counts, so it is tested first.
               if (ack_cur) begin
                  if (stg == LAST) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                  end else begin
                     stg   <= stg + 3'd1;
                     cnt   <= 32'd0;
                     state <= S_GAP;
                  end
               end else if (cnt == TIMEOUT - 32'd1) begin
                  state  <= S_ERR;
                  o_rstn <= '0;
                  o_err  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_DONE: begin
               if (i_ack != '1) begin
                  state  <= S_ERR;
                  o_rstn <= '0;
                  o_done <= 1'b0;
                  o_err  <= 1'b1;
               end
            end
            S_ERR: begin
               o_rstn <= '0;
               o_done <= 1'b0;
               o_err  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - directed self-checking bench for rst_seq
// STAGES=3, GAP=4, TIMEOUT=16; edge numbers count from the E0 of each run.
module tb_rst_seq;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic [2:0] ack;
   logic [2:0] rst_out;
   logic [2:0] stage;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;

   rst_seq #(.STAGES(3), .GAP(32'd4), .TIMEOUT(32'd16)) dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_start (start),
      .i_ack   (ack),
      .o_rstn  (rst_out),
      .o_stage (stage),
      .o_done  (done),
      .o_err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic abort_seq();
      start = 1'b0;
      ack   = 3'b000;
      adv(1);
   endtask

   initial begin
      rstn  = 1'b0;
      start = 1'b0;
      ack   = 3'b000;
      #3;
      check("rst_rstn",  rst_out, 3'b000);
      check("rst_stage", stage,   3'd0);
      check("rst_done",  done,    1'b0);
      check("rst_err",   err,     1'b0);
      adv(1);
      rstn = 1'b1;
      adv(2);
      check("idle_hold", rst_out, 3'b000);

      // Nominal: ack k sampled two edges after release k
      start = 1'b1;
      adv(1);                                   // E0
      check("nom_e0", rst_out, 3'b000);
      adv(3);                                   // E3
      check("nom_e3", rst_out, 3'b000);
      adv(1);                                   // E4
      check("nom_e4", rst_out, 3'b001);
      check("nom_stg0", stage, 3'd0);
      adv(1); ack = 3'b001; adv(1);             // E6
      check("nom_stg1", stage, 3'd1);
      adv(3);                                   // E9
      check("nom_e9", rst_out, 3'b001);
      adv(1);                                   // E10
      check("nom_e10", rst_out, 3'b011);
      adv(1); ack = 3'b011; adv(1);             // E12
      adv(4);                                   // E16
      check("nom_e16", rst_out, 3'b111);
      check("nom_stg2", stage, 3'd2);
      adv(1); ack = 3'b111;                     // E17
      check("nom_e17_done", done, 1'b0);
      adv(1);                                   // E18
      check("nom_e18_done", done, 1'b1);
      check("nom_e18_err", err, 1'b0);
      adv(2);
      check("nom_done_hold", done, 1'b1);
      check("nom_stg_hold", stage, 3'd2);

      // Async reset between edges while in DONE
      #2 rstn = 1'b0;
      #1;
      check("ar_rstn", rst_out, 3'b000);
      check("ar_done", done, 1'b0);
      check("ar_stage", stage, 3'd0);
      check("ar_err", err, 1'b0);
      #2 rstn = 1'b1;
      adv(1);                                   // new E0, acks already high
      adv(3);
      check("ar_e3", rst_out, 3'b000);
      adv(1);                                   // E4 release 0, E5 ack
      check("ar_e4", rst_out, 3'b001);
      adv(5);                                   // E9
      check("ar_e9", rst_out, 3'b011);
      adv(5);                                   // E14
      check("ar_e14", rst_out, 3'b111);
      check("ar_e14_done", done, 1'b0);
      adv(1);                                   // E15
      check("ar_e15_done", done, 1'b1);

      // Ack loss after completion
      ack = 3'b110;
      adv(1);
      check("loss_err", err, 1'b1);
      check("loss_done", done, 1'b0);
      check("loss_rstn", rst_out, 3'b000);
      ack = 3'b111;
      adv(3);
      check("loss_sticky", err, 1'b1);
      abort_seq();
      check("loss_clear", err, 1'b0);
      check("loss_stage", stage, 3'd0);

      // Timeout: ack1 never arrives, R = E10
      start = 1'b1;
      adv(1);                                   // E0
      adv(5); ack = 3'b001; adv(1);             // E6
      adv(4);                                   // E10
      check("to_e10", rst_out, 3'b011);
      adv(15);                                  // E25
      check("to_e25_err", err, 1'b0);
      check("to_e25_rstn", rst_out, 3'b011);
      adv(1);                                   // E26
      check("to_e26_err", err, 1'b1);
      check("to_e26_rstn", rst_out, 3'b000);
      check("to_e26_stage", stage, 3'd1);
      adv(4);
      check("to_hold_err", err, 1'b1);
      check("to_hold_stage", stage, 3'd1);
      abort_seq();
      check("to_abort_err", err, 1'b0);

      // Ack exactly on the timeout edge: R = E4, ack0 first sampled at E20
      start = 1'b1;
      adv(1);                                   // E0
      adv(19);                                  // E19
      check("tb_e19_err", err, 1'b0);
      check("tb_e19_rstn", rst_out, 3'b001);
      ack = 3'b001;
      adv(1);                                   // E20
      check("tb_e20_err", err, 1'b0);
      check("tb_e20_stage", stage, 3'd1);
      adv(3);                                   // E23
      check("tb_e23", rst_out, 3'b001);
      adv(1);                                   // E24
      check("tb_e24", rst_out, 3'b011);
      check("tb_e24_err", err, 1'b0);
      abort_seq();

      // Abort during stage-1 WAIT, restart next edge
      start = 1'b1;
      adv(1);                                   // E0
      adv(5); ack = 3'b001; adv(1);             // E6
      adv(6);                                   // E12, stage-1 WAIT
      check("ab_e12", rst_out, 3'b011);
      start = 1'b0;
      adv(1);                                   // X
      check("ab_x_rstn", rst_out, 3'b000);
      check("ab_x_stage", stage, 3'd0);
      check("ab_x_done", done, 1'b0);
      start = 1'b1;
      adv(1);                                   // new E0
      adv(3);
      check("ab_re3", rst_out, 3'b000);
      adv(1);
      check("ab_re4", rst_out, 3'b001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
